// File: rtl/md5_compress_core.sv
// MD5 compression core: runs one 512-bit block through the 64 MD5 steps,
// STEPS_PER_CYCLE steps per clock, and adds the result into the chaining value.
module md5_compress_core #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic         chain_in,
    output logic [127:0] digest_out,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    // Chaining words packed as {D,C,B,A}, A in the low word.
    localparam logic [127:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [5:0] STEP_INC  = 6'(STEPS_PER_CYCLE);
    localparam logic [5:0] LAST_STEP = 6'(64 - STEPS_PER_CYCLE);

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts repeat every four steps within a round: index {round, step%4}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    state_t         state_q;
    logic [5:0]     step_q;
    logic [511:0]   msg_q;
    logic [127:0]   work_q;
    logic [127:0]   work_d;
    logic [127:0]   digest_q;
    logic           chain_sel_q;
    logic           in_ready_q;
    logic           out_valid_q;

    // One MD5 step on {D,C,B,A}; returns the rotated working set.
    function automatic logic [127:0] md5_step(input logic [127:0] abcd,
                                              input logic [5:0]   idx,
                                              input logic [511:0] msg);
        logic [31:0] a, b, c, d, f, sum, rot;
        logic [3:0]  g;
        logic [4:0]  sh;
        a = abcd[31:0];
        b = abcd[63:32];
        c = abcd[95:64];
        d = abcd[127:96];
        // NOTE: defaults before the case keep every path assigned, so no latch is implied.
        f = '0;
        g = '0;
        case (idx[5:4])
            2'd0: begin f = (b & c) | (~b & d); g = idx[3:0];                end
            2'd1: begin f = (d & b) | (~d & c); g = idx[3:0] * 4'd5 + 4'd1;  end
            2'd2: begin f = b ^ c ^ d;          g = idx[3:0] * 4'd3 + 4'd5;  end
            default: begin f = c ^ (b | ~d);    g = idx[3:0] * 4'd7;         end
        endcase
        sh  = S_TAB[{idx[5:4], idx[1:0]}];
        sum = a + f + K_TAB[idx] + msg[{g, 5'd0} +: 32];
        rot = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
        return {c, b, b + rot, d};
    endfunction

    // Word-wise modulo-2^32 sum of two {D,C,B,A} sets.
    function automatic logic [127:0] add_words(input logic [127:0] x, input logic [127:0] y);
        return {x[127:96] + y[127:96], x[95:64] + y[95:64],
                x[63:32]  + y[63:32],  x[31:0]  + y[31:0]};
    endfunction

    // Unrolled chain of STEPS_PER_CYCLE consecutive steps from the current counter.
    always_comb begin
        logic [127:0] acc;
        // NOTE: blocking assignments here build a combinational chain step after step.
        acc = work_q;
        for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
            acc = md5_step(acc, step_q + 6'(j), msg_q);
        end
        work_d = acc;
    end

    // Control FSM with registered handshake outputs and the digest register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            digest_q    <= IV;
            chain_sel_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= ROUND;
                        step_q      <= '0;
                        in_ready_q  <= 1'b0;
                        chain_sel_q <= chain_in;
                    end
                end
                ROUND: begin
                    step_q <= step_q + STEP_INC;
                    if (step_q == LAST_STEP) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    digest_q    <= add_words(chain_sel_q ? digest_q : IV, work_q);
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Message and working registers: loaded on accept, stepped during ROUND.
    // NOTE: these datapath registers are deliberately not reset; the FSM never reads them before a load.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            msg_q  <= block_in;
            work_q <= chain_in ? digest_q : IV;
        end else if (state_q == ROUND) begin
            work_q <= work_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign digest_out = digest_q;

endmodule

// File: tb/tb_md5_compress_core.sv
// Bench for md5_compress_core: four instances (1, 2, 4, 8 steps per cycle) driven in
// parallel and compared against a plain-arithmetic MD5 compression model.
module tb_md5_compress_core;

    localparam int NI = 4;
    localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] DIG_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] DIG_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic         chain;
        logic [127:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_v;
    logic          in_valid;
    logic          chain_in;
    logic          out_ready;
    logic [511:0]  block_in;
    logic          in_ready_v  [NI];
    logic          out_valid_v [NI];
    logic [127:0]  digest_v    [NI];

    int checks   = 0;
    int failures = 0;

    logic [31:0]  k_tab [64];
    int           s_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                                   '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    logic [127:0] model_chain;
    vec_t         vecs [5];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        md5_compress_core #(.STEPS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .in_valid   (in_valid),
            .in_ready   (in_ready_v[g]),
            .block_in   (block_in),
            .chain_in   (chain_in),
            .digest_out (digest_v[g]),
            .out_valid  (out_valid_v[g]),
            .out_ready  (out_ready)
        );
    end

    // Reference compression: textbook MD5 round loop, K derived from |sin(i+1)|.
    function automatic logic [127:0] ref_md5(input logic [127:0] chain, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t, x;
        logic [63:0] dbl;
        int          g, s;
        a = chain[31:0];  b = chain[63:32];
        c = chain[95:64]; d = chain[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
            else if (i < 32) begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            s   = s_tab[i / 16][i % 4];
            x   = a + f + k_tab[i] + blk[32 * g +: 32];
            dbl = {x, x};
            t   = d;
            d   = c;
            c   = b;
            b   = b + dbl[63 - s -: 32];
            a   = t;
        end
        return {chain[127:96] + d, chain[95:64] + c, chain[63:32] + b, chain[31:0] + a};
    endfunction

    function automatic logic [511:0] msg_block(input logic [31:0] m0, input logic [31:0] m14);
        logic [511:0] b;
        b = '0;
        b[31:0]        = m0;
        b[14 * 32 +: 32] = m14;
        return b;
    endfunction

    function automatic bit all_valid();
        for (int i = 0; i < NI; i++) begin
            if (out_valid_v[i] !== 1'b1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Send one block to every instance, collect each digest and its latency.
    task automatic run_block(input string name, input logic [511:0] blk, input logic chain,
                             input logic [127:0] exp);
        bit           done [NI];
        int           lat  [NI];
        logic [127:0] dig  [NI];
        int           remaining;
        @(posedge clk); #1;
        block_in  = blk;
        chain_in  = chain;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_accept_s%0d", name, 1 << i), 128'(in_ready_v[i]), 128'(1));
            done[i] = 1'b0;
            lat[i]  = 0;
            dig[i]  = '0;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        remaining = NI;
        for (int c = 1; c <= 100 && remaining > 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!done[i] && out_valid_v[i] === 1'b1) begin
                    done[i] = 1'b1;
                    lat[i]  = c;
                    dig[i]  = digest_v[i];
                    remaining--;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (!done[i]) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout_s%0d: out_valid not seen in 100 cycles, expected after %0d",
                         name, 1 << i, 64 / (1 << i) + 2);
            end else begin
                check($sformatf("%s_digest_s%0d", name, 1 << i), dig[i], exp);
                check($sformatf("%s_latency_s%0d", name, 1 << i), 128'(lat[i]),
                      128'(64 / (1 << i) + 2));
            end
        end
        model_chain = exp;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] blk_a, blk_pad, blk_abc, blk_r;
        logic [127:0] snap;
        logic         ch;
        bit           seen [NI];

        for (int i = 0; i < 64; i++) begin
            real r;
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            k_tab[i] = 32'(longint'($floor(r * 4294967296.0)));
        end

        // Reset with in_valid and out_ready high: reset must win.
        rst_v     = '1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chain_in  = 1'b0;
        block_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_v    = '0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_in_ready_s%0d", 1 << i), 128'(in_ready_v[i]), 128'(1));
            check($sformatf("reset_out_valid_s%0d", 1 << i), 128'(out_valid_v[i]), 128'(0));
            check($sformatf("reset_digest_s%0d", 1 << i), digest_v[i], IV);
        end
        model_chain = IV;

        // Known-answer and chaining vectors.
        blk_abc = msg_block(32'h80636261, 32'h00000018);
        blk_a   = {16{32'h61616161}};
        blk_pad = msg_block(32'h00000080, 32'h00000200);
        vecs[0] = '{"empty_chain_after_reset", msg_block(32'h00000080, 32'h0), 1'b1, DIG_EMPTY};
        vecs[1] = '{"abc", blk_abc, 1'b0, DIG_ABC};
        vecs[2] = '{"a64_block1", blk_a, 1'b0, ref_md5(IV, blk_a)};
        vecs[3] = '{"a64_block2", blk_pad, 1'b1, ref_md5(vecs[2].exp, blk_pad)};
        vecs[4] = '{"abc_chained", blk_abc, 1'b1, ref_md5(vecs[3].exp, blk_abc)};
        for (int v = 0; v < 5; v++) begin
            run_block(vecs[v].name, vecs[v].blk, vecs[v].chain, vecs[v].exp);
        end

        // Backpressure: DONE held for 10 cycles with an in_valid pulse in the middle.
        @(posedge clk); #1;
        block_in  = blk_abc;
        chain_in  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 100 && !all_valid(); c++) @(negedge clk);
        @(negedge clk);
        check("bp_reach_done", 128'(all_valid()), 128'(1));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = (c == 3 || c == 4);
            block_in = msg_block(32'h00000080, 32'h0);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check($sformatf("bp_out_valid_c%0d_s%0d", c, 1 << i), 128'(out_valid_v[i]), 128'(1));
                check($sformatf("bp_digest_c%0d_s%0d", c, 1 << i), digest_v[i], DIG_ABC);
                check($sformatf("bp_in_ready_c%0d_s%0d", c, 1 << i), 128'(in_ready_v[i]), 128'(0));
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("bp_release_out_valid_s%0d", 1 << i), 128'(out_valid_v[i]), 128'(0));
            check($sformatf("bp_release_in_ready_s%0d", 1 << i), 128'(in_ready_v[i]), 128'(1));
            check($sformatf("bp_release_digest_s%0d", 1 << i), digest_v[i], DIG_ABC);
        end
        model_chain = DIG_ABC;

        // Reset during the cycle that performs step 30 on each instance.
        @(posedge clk); #1;
        block_in  = blk_abc;
        chain_in  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NI; i++) seen[i] = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int i = 0; i < NI; i++) rst_v[i] = (c == 30 / (1 << i) + 1);
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (out_valid_v[i] === 1'b1) seen[i] = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abort_no_out_valid_s%0d", 1 << i), 128'(seen[i]), 128'(0));
            check($sformatf("abort_in_ready_s%0d", 1 << i), 128'(in_ready_v[i]), 128'(1));
            check($sformatf("abort_digest_iv_s%0d", 1 << i), digest_v[i], IV);
        end
        model_chain = IV;
        run_block("abc_after_abort", blk_abc, 1'b1, DIG_ABC);

        // Random blocks with random chaining against the model.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 16; w++) blk_r[32 * w +: 32] = $urandom;
            ch   = 1'($urandom_range(0, 1));
            snap = ref_md5(ch ? model_chain : IV, blk_r);
            run_block($sformatf("random%0d", r), blk_r, ch, snap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/md5_compress_core.md
MD5_COMPRESS_CORE -- requirements
Module: md5_compress_core

Interface
REQ-001 Parameter STEPS_PER_CYCLE, default 1: MD5 steps evaluated per clock; legal values 1, 2, 4, 8.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  block_in and chain_in are valid this cycle.
REQ-005 in_ready  output  1  core accepts a block this cycle.
REQ-006 block_in  input  512  one padded 512-bit message block; word M[i] = block_in[32i+31:32i], little-endian as per RFC 1321.
REQ-007 chain_in  input  1  0 = start from the standard IV; 1 = start from the previous digest (multi-block message).
REQ-008 digest_out  output  128  result {D,C,B,A}: A in [31:0], B in [63:32], C in [95:64], D in [127:96].
REQ-009 out_valid  output  1  digest_out is valid.
REQ-010 out_ready  input  1  consumer accepts digest_out this cycle.

Function
REQ-011 States: IDLE, ROUND, FINAL, DONE.
REQ-012 IDLE: in_ready=1. On in_valid=1, capture block_in into the message register. Load working A..D from IV 67452301/efcdab89/98badcfe/10325476 (chain_in=0) or from the digest register (chain_in=1). Clear step counter to 0. Go to ROUND.
REQ-013 ROUND: each cycle performs STEPS_PER_CYCLE consecutive RFC 1321 steps, using F/G/H/I, K[i], shift s[i] and message index g(i) per step. Counter advances by STEPS_PER_CYCLE. After step 63, go to FINAL.
REQ-014 FINAL: digest register <= chaining input + working A..D, word-wise modulo 2^32. Go to DONE.
REQ-015 DONE: out_valid=1. On out_ready=1, go to IDLE. out_valid falls the next cycle.
REQ-016 Latency, accept to out_valid rising: 64/STEPS_PER_CYCLE + 2 cycles (66 for the default).
REQ-017 in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored.
REQ-018 digest_out holds its value from FINAL until the next FINAL, including while in IDLE; chain_in=1 uses this value.
REQ-019 All additions are 32-bit and wrap modulo 2^32; rotate is a left-rotate by s[i].
REQ-020 K[i] comes from a 64-entry constant table. s[i] and g(i) are combinational from the step index; no memory inference is required.
REQ-021 out_valid=1 with out_ready=0 holds DONE and digest_out stable indefinitely.
REQ-022 chain_in=1 on the first block after reset uses the reset digest value (the IV).

Reset
REQ-023 rst=1 at a clock edge forces IDLE, step counter=0, out_valid=0, in_ready=1 the following cycle, and digest register=IV ({10325476,98badcfe,efcdab89,67452301}).
REQ-024 rst asserted mid-ROUND or in DONE aborts the block: no out_valid pulse, no digest update.
REQ-025 rst takes priority over in_valid and out_ready in the same cycle.

Verification
REQ-026 Empty message: block_in M0=0x00000080, all other words 0, chain_in=0 -> after 66 cycles digest_out = 0x7e42f8ec_980980e9_04b2008f_d98c1dd4 (d41d8cd98f00b204e9800998ecf8427e).
REQ-027 "abc": M0=0x80636261, M14=0x00000018, others 0, chain_in=0 -> digest_out = 0x727fe128_7d3f96d6_b04fd23c_98500190 (900150983cd24fb0d6963f7d28e17f72).
REQ-028 Two-block message: 64 bytes of 'a', block 2 padded, second block sent with chain_in=1 -> digest matches a software MD5 reference.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, digest_out is stable, in_ready stays 0. Pulse in_valid meanwhile -> the pulse is ignored.
REQ-030 Reset mid-operation: assert rst at step 30 -> out_valid never pulses. The next "abc" block with chain_in=1 yields the standard "abc" digest.
REQ-031 Parameter sweep: rerun REQ-026 and REQ-027 with STEPS_PER_CYCLE=2, 4, 8 -> identical digests, with latency 34, 18, 10 cycles.
